// File: rtl/rom_load_pkg.sv
// -----------------------------------------------------------------------------
// rom_load_pkg
// Shared types and constants for the ROM download controller.
//   state_t       : controller FSM states (IDLE, LOAD, HOLD, RUN)
//   REGION_*      : base/size of the four ROM regions in the download image
//   region_match  : one-hot region hit for a download byte address
// -----------------------------------------------------------------------------
package rom_load_pkg;

    localparam int ADDR_W       = 25;
    localparam int OFFSET_W     = 12;
    localparam int REGION_COUNT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    // R0 program, R1 character, R2 sync PROM, R3 spare
    localparam logic [ADDR_W-1:0] REGION_BASE [REGION_COUNT] = '{
        25'h000_0000, 25'h000_1000, 25'h000_1800, 25'h000_1900
    };
    localparam logic [ADDR_W-1:0] REGION_SIZE [REGION_COUNT] = '{
        25'h000_1000, 25'h000_0800, 25'h000_0100, 25'h000_0100
    };

    function automatic logic [REGION_COUNT-1:0] region_match(input logic [ADDR_W-1:0] addr);
        logic [REGION_COUNT-1:0] hit;
        hit = '0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            if (addr >= REGION_BASE[i] && addr < REGION_BASE[i] + REGION_SIZE[i]) begin
                hit[i] = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/rom_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// rom_load_ctrl_if
// Download bus from hps_io plus the ROM write port it is turned into.
//   ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout : byte stream from hps_io
//   rom_we/rom_addr/rom_data                      : registered region writes
// Modports: master = byte source / ROM sink, slave = rom_load_ctrl.
// -----------------------------------------------------------------------------
interface rom_load_ctrl_if;
    import rom_load_pkg::*;

    logic                    ioctl_download;
    logic                    ioctl_wr;
    logic [ADDR_W-1:0]       ioctl_addr;
    logic [7:0]              ioctl_dout;
    logic [REGION_COUNT-1:0] rom_we;
    logic [OFFSET_W-1:0]     rom_addr;
    logic [7:0]              rom_data;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  rom_we, rom_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output rom_we, rom_addr, rom_data
    );

endinterface

// File: rtl/rom_region_decode.sv
// -----------------------------------------------------------------------------
// rom_region_decode
// Combinational address decoder for the download image.
//   addr   in  : download byte address
//   match  out : one-hot region hit (all zero when out of range)
//   offset out : addr minus the base of the hit region (zero when no hit)
// -----------------------------------------------------------------------------
module rom_region_decode
    import rom_load_pkg::*;
(
    input  logic [ADDR_W-1:0]       addr,
    output logic [REGION_COUNT-1:0] match,
    output logic [OFFSET_W-1:0]     offset
);

    assign match = region_match(addr);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        offset = '0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            if (match[i]) begin
                offset = OFFSET_W'(addr - REGION_BASE[i]);
            end
        end
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// -----------------------------------------------------------------------------
// rom_load_ctrl
// Steers the hps_io ROM download into four region write ports, checks the
// download length and holds the game core in reset until the image is in.
//   clk_sys, reset (sync, active-high)
//   bus        : rom_load_ctrl_if.slave (ioctl_* in, rom_we/rom_addr/rom_data out)
//   user_reset : OSD/button reset request, level
//   core_reset : reset to the game core, low only in RUN
//   oob_err    : sticky, a byte landed outside every region
//   size_err   : sticky, byte count differed from EXP_BYTES at end of download
// Optional feature macro ROM_CHECKSUM_EN adds checksum[7:0] and chk_ok; while
// chk_ok is low the core is never released.
// -----------------------------------------------------------------------------
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int         RST_HOLD  = 16,
    parameter int         EXP_BYTES = 6656,
    parameter logic [7:0] EXP_SUM   = 8'h00
) (
    input  logic           clk_sys,
    input  logic           reset,
    rom_load_ctrl_if.slave bus,
    input  logic           user_reset,
    output logic           core_reset,
    output logic           oob_err,
    output logic           size_err
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [7:0]     checksum,
    output logic           chk_ok
`endif
);

    state_t                  state;
    state_t                  next_state;
    logic                    dl_q;
    logic                    dl_rise;
    logic                    dl_fall;
    logic [7:0]              hold_cnt;
    logic [16:0]             byte_count;
    logic [REGION_COUNT-1:0] match;
    logic [OFFSET_W-1:0]     offset;
    logic                    hold_ok;
    logic                    enter_load;
    logic                    accept;

    rom_region_decode u_decode (
        .addr   (bus.ioctl_addr),
        .match  (match),
        .offset (offset)
    );

    assign dl_rise    = bus.ioctl_download & ~dl_q;
    assign dl_fall    = ~bus.ioctl_download & dl_q;
    assign accept     = (state == LOAD) && bus.ioctl_wr;
    assign enter_load = (next_state == LOAD) && (state != LOAD);

`ifdef ROM_CHECKSUM_EN
    assign hold_ok = chk_ok;
`else
    assign hold_ok = 1'b1;
    logic unused_exp_sum;
    assign unused_exp_sum = ^EXP_SUM;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state is always updated with non-blocking assignments.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (dl_rise) next_state = LOAD;
            LOAD: if (dl_fall) next_state = HOLD;
            HOLD: begin
                if (dl_rise) begin
                    next_state = LOAD;
                end else if (!user_reset && hold_cnt == 8'd0 && hold_ok) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (dl_rise) begin
                    next_state = LOAD;
                end else if (user_reset) begin
                    next_state = HOLD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Hold counter: cycles with user_reset high do not count toward the stretch,
    // so the core stays in reset for RST_HOLD cycles after the last request
    // cycle. Arriving from LOAD, the entry cycle itself is the first hold cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_cnt <= 8'd0;
        end else if (next_state == HOLD) begin
            if (user_reset) begin
                hold_cnt <= 8'(RST_HOLD);
            end else if (state != HOLD) begin
                hold_cnt <= 8'(RST_HOLD - 1);
            end else if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: dl_q follows the pin even in reset so a download still high
            // when reset drops is not mistaken for a new rising edge.
            dl_q         <= bus.ioctl_download;
            core_reset   <= 1'b1;
            bus.rom_we   <= '0;
            bus.rom_addr <= '0;
            bus.rom_data <= '0;
            byte_count   <= '0;
            oob_err      <= 1'b0;
            size_err     <= 1'b0;
        end else begin
            dl_q       <= bus.ioctl_download;
            core_reset <= (next_state != RUN);
            bus.rom_we <= '0;
            if (enter_load) begin
                byte_count <= '0;
                oob_err    <= 1'b0;
                size_err   <= 1'b0;
            end else begin
                if (accept) begin
                    if (byte_count != '1) begin
                        byte_count <= byte_count + 17'd1;
                    end
                    if (match == '0) begin
                        oob_err <= 1'b1;
                    end else begin
                        bus.rom_we   <= match;
                        bus.rom_addr <= offset;
                        bus.rom_data <= bus.ioctl_dout;
                    end
                end
                // Length is judged on the count before any byte strobed in the
                // same cycle as the download window closes.
                if (state == LOAD && next_state == HOLD) begin
                    size_err <= (byte_count != 17'(EXP_BYTES));
                end
            end
        end
    end

`ifdef ROM_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            checksum <= 8'h00;
            chk_ok   <= 1'b0;
        end else if (enter_load) begin
            checksum <= 8'h00;
            chk_ok   <= 1'b0;
        end else begin
            if (accept && match != '0) begin
                checksum <= checksum + bus.ioctl_dout;
            end
            if (state == LOAD && next_state == HOLD) begin
                chk_ok <= (checksum == EXP_SUM);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rom_load_ctrl
// Directed + randomized bench for rom_load_ctrl. A behavioural model derives
// expected region writes, byte count, error flags and checksum from the region
// table; core_reset release timing is predicted from RST_HOLD.
// Build with +define+ROM_CHECKSUM_EN to exercise the checksum gate.
// -----------------------------------------------------------------------------
module tb_rom_load_ctrl;
    import rom_load_pkg::*;

    localparam int         RST_HOLD  = 16;
    localparam int         EXP_BYTES = 6656;
    localparam logic [7:0] EXP_SUM   = 8'h00;
    localparam int         LIMIT     = 64;

    logic clk_sys = 1'b0;
    logic reset;
    logic user_reset;
    logic core_reset;
    logic oob_err;
    logic size_err;
`ifdef ROM_CHECKSUM_EN
    logic [7:0] checksum;
    logic       chk_ok;
`endif

    rom_load_ctrl_if bus ();

    rom_load_ctrl #(
        .RST_HOLD  (RST_HOLD),
        .EXP_BYTES (EXP_BYTES),
        .EXP_SUM   (EXP_SUM)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus),
        .user_reset (user_reset),
        .core_reset (core_reset),
        .oob_err    (oob_err),
        .size_err   (size_err)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum   (checksum),
        .chk_ok     (chk_ok)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int errors    = 0;
    int checks    = 0;
    int bad_bytes = 0;
    int we_pulses = 0;

    // model state
    bit         model_in_load = 1'b0;
    int         exp_count     = 0;
    bit         exp_oob       = 1'b0;
    logic [7:0] exp_sum       = 8'h00;

    always @(negedge clk_sys) begin
        if ((|bus.rom_we) === 1'b1) we_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Region table straight from the memory map: returns -1 when out of range.
    function automatic int region_of(input int a);
        if (a < 'h1000) return 0;
        if (a < 'h1800) return 1;
        if (a < 'h1900) return 2;
        if (a < 'h1A00) return 3;
        return -1;
    endfunction

    function automatic int base_of(input int r);
        case (r)
            0:       return 'h0000;
            1:       return 'h1000;
            2:       return 'h1800;
            default: return 'h1900;
        endcase
    endfunction

    function automatic bit release_expected();
`ifdef ROM_CHECKSUM_EN
        return exp_sum == EXP_SUM;
`else
        return 1'b1;
`endif
    endfunction

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int         r;
        logic [3:0] exp_we;
        logic [11:0] exp_addr;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        step();
        bus.ioctl_wr = 1'b0;
        r        = region_of(int'(a));
        exp_we   = 4'b0000;
        exp_addr = 12'h000;
        if (model_in_load) begin
            exp_count++;
            if (r < 0) begin
                exp_oob = 1'b1;
            end else begin
                exp_we   = 4'(1 << r);
                exp_addr = 12'(int'(a) - base_of(r));
                exp_sum  = exp_sum + d;
            end
        end
        if (bus.rom_we !== exp_we ||
            (exp_we != 4'b0000 && (bus.rom_addr !== exp_addr || bus.rom_data !== d)))
            bad_bytes++;
    endtask

    task automatic start_download(input string tag);
        bus.ioctl_download = 1'b1;
        step();
        model_in_load = 1'b1;
        exp_count     = 0;
        exp_oob       = 1'b0;
        exp_sum       = 8'h00;
        bad_bytes     = 0;
        check({tag, "_oob_clr"}, 32'(oob_err), 32'(0));
        check({tag, "_size_clr"}, 32'(size_err), 32'(0));
        check({tag, "_core_rst"}, 32'(core_reset), 32'(1));
    endtask

    // Counts consecutive samples with core_reset high, starting at n0, bounded.
    task automatic measure_release(input string tag, input int n0, input int exp_n);
        int n;
        n = n0;
        while (core_reset === 1'b1 && n < LIMIT) begin
            step();
            if (core_reset === 1'b1) n++;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic end_download(input string tag);
        bus.ioctl_download = 1'b0;
        step();
        model_in_load = 1'b0;
        check({tag, "_bytes"}, 32'(bad_bytes), 32'(0));
        check({tag, "_size_err"}, 32'(size_err), 32'(exp_count != EXP_BYTES));
        check({tag, "_oob_err"}, 32'(oob_err), 32'(exp_oob));
`ifdef ROM_CHECKSUM_EN
        check({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
        check({tag, "_chk_ok"}, 32'(chk_ok), 32'(exp_sum == EXP_SUM));
`endif
        measure_release({tag, "_release"}, (core_reset === 1'b1) ? 1 : 0,
                        release_expected() ? RST_HOLD : LIMIT);
    endtask

    initial begin
        int pulses0;
        int n;
        reset              = 1'b1;
        user_reset         = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        repeat (3) step();

        // reset state
        check("rst_rom_we", 32'(bus.rom_we), 32'(0));
        check("rst_rom_addr", 32'(bus.rom_addr), 32'(0));
        check("rst_rom_data", 32'(bus.rom_data), 32'(0));
        check("rst_core_reset", 32'(core_reset), 32'(1));
        check("rst_oob", 32'(oob_err), 32'(0));
        check("rst_size", 32'(size_err), 32'(0));
        check("rst_count", 32'(dut.byte_count), 32'(0));
`ifdef ROM_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'(0));
`endif
        reset = 1'b0;
        repeat (2) step();

        // strobes outside LOAD are ignored
        bad_bytes = 0;
        send_byte(25'h10, 8'hA5);
        send_byte(25'h1A00, 8'h5A);
        check("idle_wr_ignored", 32'(bad_bytes), 32'(0));
        check("idle_oob", 32'(oob_err), 32'(0));
        check("idle_core_reset", 32'(core_reset), 32'(1));

        // full image, data = low address byte
        start_download("full");
        pulses0 = we_pulses;
        for (int a = 0; a < 'h1A00; a++) begin
            send_byte(25'(a), 8'(a));
            if (a == 'h1000) begin
                check("full_we_at_1000", 32'(bus.rom_we), 32'(4'b0010));
                check("full_addr_at_1000", 32'(bus.rom_addr), 32'(0));
            end
        end
        step();
        check("full_pulses", 32'(we_pulses - pulses0), 32'(6656));
        check("full_count", 32'(dut.byte_count), 32'(6656));
        end_download("full");
        check("full_run", 32'(core_reset), 32'(0));

        // user_reset pulse of 3 cycles in RUN
        user_reset = 1'b1;
        n = 0;
        repeat (3) begin
            step();
            if (core_reset === 1'b1) n++;
        end
        user_reset = 1'b0;
        measure_release("ureset_release", n, 3 + RST_HOLD);
        check("ureset_count", 32'(dut.byte_count), 32'(6656));
        check("ureset_oob", 32'(oob_err), 32'(0));
        check("ureset_size", 32'(size_err), 32'(0));

        // out-of-range byte
        start_download("oob");
        for (int i = 0; i < 5; i++) send_byte(25'($urandom_range(0, 'h19FF)), 8'($urandom));
        send_byte(25'h1A00, 8'($urandom));
        check("oob_no_we", 32'(bus.rom_we), 32'(0));
        check("oob_set", 32'(oob_err), 32'(1));
        for (int i = 0; i < 3; i++) send_byte(25'($urandom_range(0, 'h19FF)), 8'($urandom));
        check("oob_sticky_load", 32'(oob_err), 32'(1));
        end_download("oob");
        repeat (5) step();
        check("oob_sticky_after", 32'(oob_err), 32'(1));

        // short 100-byte random download
        start_download("short");
        for (int i = 0; i < 100; i++) send_byte(25'($urandom_range(0, 'h19FF)), 8'($urandom));
        check("short_count", 32'(dut.byte_count), 32'(100));
        end_download("short");

        // reset in the middle of LOAD
        start_download("rstmid");
        for (int i = 0; i < 50; i++) send_byte(25'($urandom_range(0, 'h19FF)), 8'($urandom));
        check("rstmid_count50", 32'(dut.byte_count), 32'(50));
        reset          = 1'b1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h20;
        step();
        reset         = 1'b0;
        bus.ioctl_wr  = 1'b0;
        model_in_load = 1'b0;
        check("rstmid_state", 32'(dut.state), 32'(IDLE));
        check("rstmid_we", 32'(bus.rom_we), 32'(0));
        check("rstmid_count", 32'(dut.byte_count), 32'(0));
        check("rstmid_core_reset", 32'(core_reset), 32'(1));
        bad_bytes = 0;
        for (int i = 0; i < 5; i++) send_byte(25'($urandom_range(0, 'h19FF)), 8'($urandom));
        check("rstmid_ignored", 32'(bad_bytes), 32'(0));
        check("rstmid_count_after", 32'(dut.byte_count), 32'(0));
        bus.ioctl_download = 1'b0;
        step();
        start_download("reload");
        send_byte(25'h1805, 8'h3C);
        check("reload_we", 32'(bus.rom_we), 32'(4'b0100));
        check("reload_addr", 32'(bus.rom_addr), 32'(5));
        check("reload_count", 32'(dut.byte_count), 32'(1));
        end_download("reload");

`ifdef ROM_CHECKSUM_EN
        // bytes summing to 0x01 against EXP_SUM 0x00: core never released
        start_download("badsum");
        send_byte(25'h0000, 8'h00);
        send_byte(25'h1900, 8'h01);
        end_download("badsum");
        check("badsum_core_reset", 32'(core_reset), 32'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
